spi_byte_shifter: RTL and testbench

SPI mode-0 byte engine for the SD card controller. It sits between the TX/RX byte FIFOs and the SD card pins. It takes bytes from the TX FIFO through a one-byte input register and serialises them on MOSI/SCLK. It captures MISO bytes into a one-byte output register that the RX FIFO drains. It also runs autonomous receive-only bursts of a programmed byte length.

---
 rtl/spi_byte_shifter.sv | 182 ++++++++++++++++++
 tb/tb_spi_byte_shifter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine between the TX/RX byte FIFOs and the SD card pins.
// Build option SPI_SHIFTER_MISO_SYNC_EN: two-flop MISO synchroniser, clk_div clamped to >= 2.
module spi_byte_shifter #(
   parameter int unsigned CLKDIV_W = 8,
   parameter int unsigned RXLEN_W  = 13
) (
   input  logic                C100M,
   input  logic                RESET_n,
   input  logic [CLKDIV_W-1:0] clk_div,
   input  logic [1:0]          mode,
   input  logic [RXLEN_W-1:0]  new_rx_length,
   input  logic                set_rx_length,
   input  logic                wr_req,
   input  logic [7:0]          data_in,
   output logic                in_full,
   input  logic                rd_req,
   output logic [7:0]          data_out,
   output logic                out_full,
   output logic                busy,
   input  logic                MISO,
   output logic                MOSI,
   output logic                SCLK
);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_STALL} state_e;

   state_e               state_q;
   logic [1:0]           mode_q;
   logic [7:0]           shift_q;
   logic [2:0]           bit_cnt_q;
   logic [CLKDIV_W-1:0]  div_cnt_q;
   logic [7:0]           in_reg_q;
   logic                 in_full_q;
   logic [7:0]           out_reg_q;
   logic                 out_full_q;
   logic [RXLEN_W-1:0]   rx_cnt_q;
   logic                 sclk_q;
   logic                 mosi_q;

   logic [CLKDIV_W-1:0]  div_lim;
   logic                 miso_bit;
   logic                 start_tx;
   logic                 start_rx;
   logic                 half_end;
   logic                 done;
   logic                 keep_rx;
   logic                 hand_off;
   logic [7:0]           shift_nxt;
   logic [7:0]           rx_byte;

`ifdef SPI_SHIFTER_MISO_SYNC_EN
   logic miso_s1_q;
   logic miso_s2_q;

   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         miso_s1_q <= 1'b0;
         miso_s2_q <= 1'b0;
      end else begin
         miso_s1_q <= MISO;
         miso_s2_q <= miso_s1_q;
      end
   end

   // Synchroniser latency needs at least three cycles per SCLK phase.
   assign div_lim  = (clk_div < CLKDIV_W'(2)) ? CLKDIV_W'(2) : clk_div;
   assign miso_bit = miso_s2_q;
`else
   logic miso_smp_q;

   assign div_lim  = clk_div;
   assign miso_bit = miso_smp_q;
`endif

   assign start_tx  = (state_q == S_IDLE) && (mode != 2'd2) && in_full_q;
   assign start_rx  = (state_q == S_IDLE) && (mode == 2'd2) && (rx_cnt_q != '0);
   assign half_end  = (div_cnt_q == div_lim);
   assign done      = (state_q == S_HIGH) && half_end && (bit_cnt_q == 3'd7);
   assign keep_rx   = (mode_q == 2'd1) || (mode_q == 2'd2);
   assign shift_nxt = {shift_q[6:0], miso_bit};
   // A stalled byte was already shifted in on completion; a direct hand-off takes the final shift.
   assign rx_byte   = (state_q == S_STALL) ? shift_q : shift_nxt;
   assign hand_off  = ((done && keep_rx) || (state_q == S_STALL)) && !out_full_q;

   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         in_reg_q   <= '0;
         in_full_q  <= 1'b0;
         out_reg_q  <= '0;
         out_full_q <= 1'b0;
         rx_cnt_q   <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b1;
`ifndef SPI_SHIFTER_MISO_SYNC_EN
         miso_smp_q <= 1'b0;
`endif
      end else begin
         if (start_tx)
            in_full_q <= 1'b0;
         if (wr_req && (!in_full_q || start_tx)) begin
            in_reg_q  <= data_in;
            in_full_q <= 1'b1;
         end

         if (rd_req)
            out_full_q <= 1'b0;
         if (hand_off) begin
            out_reg_q  <= rx_byte;
            out_full_q <= 1'b1;
         end

         if (set_rx_length)
            rx_cnt_q <= new_rx_length;
         else if (hand_off && (mode_q == 2'd2) && (rx_cnt_q != '0))
            rx_cnt_q <= rx_cnt_q - RXLEN_W'(1);

         case (state_q)
            S_IDLE: begin
               sclk_q <= 1'b0;
               mosi_q <= 1'b1;
               mode_q <= mode;
               if (start_tx || start_rx) begin
                  shift_q   <= start_tx ? in_reg_q : 8'hFF;
                  mosi_q    <= start_tx ? in_reg_q[7] : 1'b1;
                  bit_cnt_q <= '0;
                  div_cnt_q <= '0;
                  state_q   <= S_LOW;
               end
            end
            S_LOW: begin
               if (half_end) begin
                  sclk_q    <= 1'b1;
                  div_cnt_q <= '0;
                  state_q   <= S_HIGH;
`ifndef SPI_SHIFTER_MISO_SYNC_EN
                  miso_smp_q <= MISO;
`endif
               end else begin
                  div_cnt_q <= div_cnt_q + CLKDIV_W'(1);
               end
            end
            S_HIGH: begin
               if (half_end) begin
                  sclk_q    <= 1'b0;
                  div_cnt_q <= '0;
                  shift_q   <= shift_nxt;
                  if (bit_cnt_q == 3'd7) begin
                     mosi_q  <= 1'b1;
                     state_q <= (keep_rx && out_full_q) ? S_STALL : S_IDLE;
                  end else begin
                     mosi_q    <= shift_q[6];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     state_q   <= S_LOW;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + CLKDIV_W'(1);
               end
            end
            S_STALL: begin
               sclk_q <= 1'b0;
               mosi_q <= 1'b1;
               if (!out_full_q)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_full  = in_full_q;
   assign data_out = out_reg_q;
   assign out_full = out_full_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign busy     = (state_q != S_IDLE) | in_full_q | ((mode == 2'd2) & (rx_cnt_q != '0));

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: models a mode-0 card that shifts MISO on SCLK falls.
module tb_spi_byte_shifter;

   localparam int CW = 8;
   localparam int RW = 13;

   logic          C100M = 1'b0;
   logic          RESET_n = 1'b0;
   logic [CW-1:0] clk_div = '0;
   logic [1:0]    mode = '0;
   logic [RW-1:0] new_rx_length = '0;
   logic          set_rx_length = 1'b0;
   logic          wr_req = 1'b0;
   logic [7:0]    data_in = '0;
   logic          rd_req = 1'b0;
   logic          in_full;
   logic [7:0]    data_out;
   logic          out_full;
   logic          busy;
   logic          MISO;
   logic          MOSI;
   logic          SCLK;

   int n_chk = 0;
   int n_bad = 0;

   spi_byte_shifter #(.CLKDIV_W(CW), .RXLEN_W(RW)) dut (
      .C100M(C100M), .RESET_n(RESET_n), .clk_div(clk_div), .mode(mode),
      .new_rx_length(new_rx_length), .set_rx_length(set_rx_length),
      .wr_req(wr_req), .data_in(data_in), .in_full(in_full),
      .rd_req(rd_req), .data_out(data_out), .out_full(out_full),
      .busy(busy), .MISO(MISO), .MOSI(MOSI), .SCLK(SCLK)
   );

   always #5 C100M = ~C100M;

   int          rise_cnt = 0;
   int          fall_cnt = 0;
   int          mosi0_cnt = 0;
   logic [15:0] mosi_sr = '0;
   longint      rise_t [256];

   always @(posedge SCLK) begin
      rise_t[rise_cnt % 256] = $time;
      mosi_sr = {mosi_sr[14:0], MOSI};
      if (!MOSI) mosi0_cnt++;
      rise_cnt++;
   end

   always @(negedge SCLK) fall_cnt++;

   logic [7:0] miso_byte = '0;
   int         miso_base = 0;
   logic [2:0] miso_idx;
   assign miso_idx = 3'(fall_cnt - miso_base);
   assign MISO     = miso_byte[3'd7 - miso_idx];

   function automatic int eff(input int d);
`ifdef SPI_SHIFTER_MISO_SYNC_EN
      return (d < 2) ? 2 : d;
`else
      return d;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge C100M);
      wr_req  = 1'b1;
      data_in = b;
      @(negedge C100M);
      wr_req  = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge C100M);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic drain(input string tag, input logic [7:0] exp, output int nb);
      nb = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge C100M);
         if (out_full) begin
            chk(tag, 32'(data_out), 32'(exp));
            rd_req = 1'b1;
            @(negedge C100M);
            rd_req = 1'b0;
            nb++;
         end
         if (!busy && !out_full) break;
      end
      chk({tag, "_end"}, 32'({busy, out_full}), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      int n;
      int nb;
      int r0;
      int z0;

      repeat (3) @(negedge C100M);
      chk("rst_sclk", 32'(SCLK), 32'd0);
      chk("rst_mosi", 32'(MOSI), 32'd1);
      chk("rst_in_full", 32'(in_full), 32'd0);
      chk("rst_out_full", 32'(out_full), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'h00);
      RESET_n = 1'b1;
      @(negedge C100M);

      // Mode 0 TX only, clk_div 0
      mode = 2'd0; clk_div = 8'd0;
      r0 = rise_cnt;
      write_byte(8'hA5);
      chk("t1_in_full", 32'(in_full), 32'd1);
      wait_idle("t1", n);
      chk("t1_cycles", 32'(n), 32'(1 + 16 * (eff(0) + 1)));
      chk("t1_rises", 32'(rise_cnt - r0), 32'd8);
      chk("t1_mosi", 32'(mosi_sr[7:0]), 32'hA5);
      chk("t1_out_full", 32'(out_full), 32'd0);
      chk("t1_mosi_idle", 32'(MOSI), 32'd1);

      // Mode 1 full duplex, clk_div 3
      mode = 2'd1; clk_div = 8'd3;
      miso_byte = 8'hC3; miso_base = fall_cnt;
      r0 = rise_cnt;
      write_byte(8'h3C);
      wait_idle("t2", n);
      chk("t2_cycles", 32'(n), 32'd65);
      chk("t2_data", 32'(data_out), 32'hC3);
      chk("t2_out_full", 32'(out_full), 32'd1);
      chk("t2_mosi", 32'(mosi_sr[7:0]), 32'h3C);
      chk("t2_period", 32'(rise_t[(r0 + 7) % 256] - rise_t[(r0 + 6) % 256]), 32'd80);
      @(negedge C100M); rd_req = 1'b1;
      @(negedge C100M); rd_req = 1'b0;
      chk("t2_pop", 32'(out_full), 32'd0);

      // Mode 2 RX burst of 3, first byte held back to force a stall
      clk_div = 8'd1;
      miso_byte = 8'h5A; miso_base = fall_cnt;
      r0 = rise_cnt; z0 = mosi0_cnt;
      @(negedge C100M);
      mode = 2'd2; new_rx_length = 13'd3; set_rx_length = 1'b1;
      @(negedge C100M);
      set_rx_length = 1'b0;
      chk("t3_busy", 32'(busy), 32'd1);
      n = 0;
      while (!out_full && n < 2000) begin
         @(negedge C100M);
         n++;
      end
      chk("t3_first", 32'(data_out), 32'h5A);
      repeat (3 * (1 + 16 * (eff(1) + 1))) @(negedge C100M);
      chk("t3_stall_rises", 32'(rise_cnt - r0), 32'd16);
      chk("t3_stall_sclk", 32'(SCLK), 32'd0);
      chk("t3_stall_busy", 32'(busy), 32'd1);
      drain("t3_data", 8'h5A, nb);
      chk("t3_bytes", 32'(nb), 32'd3);
      chk("t3_rises", 32'(rise_cnt - r0), 32'd24);
      chk("t3_mosi_high", 32'(mosi0_cnt - z0), 32'd0);
      mode = 2'd0;

      // Mode 1, second write lands on the consume cycle
      @(negedge C100M);
      mode = 2'd1; clk_div = 8'd0;
      miso_byte = 8'hE7; miso_base = fall_cnt;
      r0 = rise_cnt;
      @(negedge C100M);
      wr_req = 1'b1; data_in = 8'h96;
      @(negedge C100M);
      data_in = 8'h69;
      @(negedge C100M);
      wr_req = 1'b0;
      chk("t4_in_full", 32'(in_full), 32'd1);
      drain("t4_data", 8'hE7, nb);
      chk("t4_bytes", 32'(nb), 32'd2);
      chk("t4_rises", 32'(rise_cnt - r0), 32'd16);
      chk("t4_mosi", 32'(mosi_sr), 32'h9669);
      chk("t4_inner", 32'(rise_t[(r0 + 1) % 256] - rise_t[r0 % 256]), 32'(20 * (eff(0) + 1)));
      chk("t4_gap", 32'(rise_t[(r0 + 8) % 256] - rise_t[(r0 + 7) % 256]), 32'(10 * (2 * eff(0) + 3)));

      // Reset during bit 4 of a mode 1 byte, with a byte waiting in data_out
      clk_div = 8'd3;
      miso_byte = 8'hB4; miso_base = fall_cnt;
      write_byte(8'h11);
      wait_idle("t5a", n);
      chk("t5_pre_data", 32'(data_out), 32'hB4);
      miso_byte = 8'h00; miso_base = fall_cnt;
      r0 = rise_cnt;
      write_byte(8'hF0);
      n = 0;
      while ((rise_cnt - r0) < 5 && n < 2000) begin
         @(negedge C100M);
         n++;
      end
      chk("t5_reach_bit4", 32'(rise_cnt - r0), 32'd5);
      chk("t5_pre_sclk", 32'(SCLK), 32'd1);
      chk("t5_pre_out_full", 32'(out_full), 32'd1);
      RESET_n = 1'b0;
      #1;
      chk("t5_sclk", 32'(SCLK), 32'd0);
      chk("t5_mosi", 32'(MOSI), 32'd1);
      chk("t5_in_full", 32'(in_full), 32'd0);
      chk("t5_out_full", 32'(out_full), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_data_out", 32'(data_out), 32'h00);
      @(negedge C100M);
      RESET_n = 1'b1;
      miso_byte = 8'h3A; miso_base = fall_cnt;
      r0 = rise_cnt;
      write_byte(8'h5C);
      wait_idle("t5b", n);
      chk("t5_after_rises", 32'(rise_cnt - r0), 32'd8);
      chk("t5_after_mosi", 32'(mosi_sr[7:0]), 32'h5C);
      chk("t5_after_data", 32'(data_out), 32'h3A);
      chk("t5_after_full", 32'(out_full), 32'd1);
      @(negedge C100M); rd_req = 1'b1;
      @(negedge C100M); rd_req = 1'b0;

`ifdef SPI_SHIFTER_MISO_SYNC_EN
      // Synchronised MISO: clk_div 0 is clamped to 2
      clk_div = 8'd0;
      miso_byte = 8'h81; miso_base = fall_cnt;
      r0 = rise_cnt;
      write_byte(8'h42);
      wait_idle("t6", n);
      chk("t6_data", 32'(data_out), 32'h81);
      chk("t6_period", 32'(rise_t[(r0 + 1) % 256] - rise_t[r0 % 256]), 32'd60);
      chk("t6_mosi", 32'(mosi_sr[7:0]), 32'h42);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
